mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-port word memory that answers one request at a time
// after a fixed LATENCY.
//
// A request is accepted in IDLE. The block then waits LATENCY-1 cycles in WAIT
// and raises mem_resp for one cycle in RESP. On the edge that enters RESP, the
// block commits a write, or it captures the read data.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, 2..4096)
//   LATENCY      cycles from the acceptance cycle to the mem_resp cycle (1..15)
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset (storage is not cleared)
//   mem_read         read request, held until mem_resp
//   mem_write        write request, held until mem_resp (a read wins if both are high)
//   mem_address      byte address; word index = mem_address[log2(DEPTH_WORDS)+1:2]
//   mem_byte_enable  write lane enables, bit i covers wdata[8i+7:8i]
//   mem_wdata        write data
//   mem_rdata        full stored word, updated on each read response and then held
//   mem_resp         one-cycle completion pulse
//   proto_err        sticky protocol-violation flag
//
// Optional feature: define MEM_RESPONDER_PROTO_CHECK_EN to build the protocol
// checker behind proto_err. Without the macro, proto_err is tied to 0.

module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        proto_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // WAIT lasts LATENCY-1 cycles. The counter counts down to 0, so it is loaded with LATENCY-2.
  localparam logic [3:0] CNT_LOAD = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            is_write_q;
  logic [AW-1:0]   idx_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            resp_q;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            req;
  logic            accept;
  logic            in_is_write;
  logic            go_resp;
  logic            acc_is_write;
  logic [AW-1:0]   acc_idx;
  logic [3:0]      acc_be;
  logic [31:0]     acc_wdata;
  logic            mem_we;

  // Only the word-index bits of the address matter here.
  logic unused_addr;
  assign unused_addr = ^{mem_address[31:AW+2], mem_address[1:0]};

  assign req         = mem_read | mem_write;
  assign accept      = (state_q == StIdle) && req;
  assign in_is_write = mem_write & ~mem_read;

  // With LATENCY=1, the edge that accepts a request is also the edge that
  // enters RESP. The access then has to use the live inputs instead of the
  // latched copies.
  assign go_resp = (accept && (LATENCY == 1)) || ((state_q == StWait) && (cnt_q == 4'd0));

  always_comb begin
    acc_is_write = is_write_q;
    acc_idx      = idx_q;
    acc_be       = be_q;
    acc_wdata    = wdata_q;
    if (state_q == StIdle) begin
      acc_is_write = in_is_write;
      acc_idx      = mem_address[AW+1:2];
      acc_be       = mem_byte_enable;
      acc_wdata    = mem_wdata;
    end
  end

  // Reset blocks the commit, so a transaction aborted in WAIT leaves memory untouched.
  assign mem_we = ~rst & go_resp & acc_is_write;

  // Storage has no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      is_write_q <= 1'b0;
      idx_q      <= '0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      resp_q     <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req) begin
            is_write_q <= in_is_write;
            idx_q      <= mem_address[AW+1:2];
            be_q       <= mem_byte_enable;
            wdata_q    <= mem_wdata;
            cnt_q      <= CNT_LOAD;
            state_q    <= (LATENCY == 1) ? StResp : StWait;
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
      if (go_resp) begin
        resp_q <= 1'b1;
        if (!acc_is_write) begin
          rdata_q <= mem[acc_idx];
        end
      end
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_resp  = resp_q;

`ifdef MEM_RESPONDER_PROTO_CHECK_EN
  logic [31:0] addr_q;
  logic        proto_err_q;
  logic        viol;

  always_comb begin
    viol = 1'b0;
    if (accept && mem_read && mem_write) begin
      viol = 1'b1;
    end
    if (accept && in_is_write && (mem_byte_enable == 4'd0)) begin
      viol = 1'b1;
    end
    if (state_q == StWait) begin
      // The initiator must keep the accepted request and its fields stable until mem_resp.
      if (is_write_q ? !mem_write : !mem_read) begin
        viol = 1'b1;
      end
      if ((mem_address != addr_q) || (mem_wdata != wdata_q) || (mem_byte_enable != be_q)) begin
        viol = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= 32'd0;
      proto_err_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= mem_address;
      end
      if (viol) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder.
//
// u_dut:  DEPTH_WORDS=256, LATENCY=3. Receives directed cases and random
//         transactions, checked against an array model.
// u_dut1: DEPTH_WORDS=16, LATENCY=1. Receives back-to-back traffic.

module tb_mem_responder;

`ifdef MEM_RESPONDER_PROTO_CHECK_EN
  localparam bit PROTO_EN = 1'b1;
`else
  localparam bit PROTO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_address = 32'd0;
  logic [3:0]  mem_byte_enable = 4'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        proto_err;

  logic        l1_read = 1'b0;
  logic        l1_write = 1'b0;
  logic [31:0] l1_address = 32'd0;
  logic [3:0]  l1_byte_enable = 4'd0;
  logic [31:0] l1_wdata = 32'd0;
  logic [31:0] l1_rdata;
  logic        l1_resp;
  logic        l1_proto_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ref_mem  [256];
  logic [31:0] ref_mem1 [16];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  mem_responder #(
    .DEPTH_WORDS(256),
    .LATENCY    (3)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_byte_enable(mem_byte_enable),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp),
    .proto_err      (proto_err)
  );

  mem_responder #(
    .DEPTH_WORDS(16),
    .LATENCY    (1)
  ) u_dut1 (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (l1_read),
    .mem_write      (l1_write),
    .mem_address    (l1_address),
    .mem_byte_enable(l1_byte_enable),
    .mem_wdata      (l1_wdata),
    .mem_rdata      (l1_rdata),
    .mem_resp       (l1_resp),
    .proto_err      (l1_proto_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Runs one transaction on u_dut, starting and ending at posedge+1 in IDLE.
  // lat is the number of cycles from the acceptance cycle to the mem_resp cycle.
  task automatic txn(input bit wr, input bit rd, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input bit perturb,
                     output logic [31:0] rdata, output int lat);
    mem_write       = wr;
    mem_read        = rd;
    mem_address     = addr;
    mem_byte_enable = be;
    mem_wdata       = wd;
    @(posedge clk); #1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (mem_resp) begin
        lat = i;
        break;
      end
      if (perturb) begin
        mem_address     = $urandom;
        mem_wdata       = $urandom;
        mem_byte_enable = 4'($urandom);
      end
      @(posedge clk); #1;
    end
    rdata     = mem_rdata;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk); #1;
    check_eq("resp_pulse", 32'(mem_resp), 32'd0);
  endtask

  // Runs one transaction and checks latency and rdata against the model.
  task automatic run(input bit wr, input bit rd, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input bit perturb, input string tag);
    logic [31:0] got;
    logic [31:0] exp;
    int          lat;
    int          idx;
    idx = int'(addr[9:2]);
    if (rd) begin
      exp     = ref_mem[idx];
      last_rd = exp;
    end else begin
      ref_mem[idx] = (ref_mem[idx] & ~lane_mask(be)) | (wd & lane_mask(be));
      exp          = last_rd;
    end
    txn(wr, rd, addr, be, wd, perturb, got, lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'd3);
    check_eq({tag, "_rdata"}, got, exp);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst     = 1'b0;
    last_rd = 32'd0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    bit          wr;
    bit          rd;
    bit          saw_resp;

    last_rd = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset_resp", 32'(mem_resp), 32'd0);
    check_eq("reset_rdata", mem_rdata, 32'd0);
    check_eq("reset_proto_err", 32'(proto_err), 32'd0);

    // Fill every word so no read ever returns uninitialised storage.
    for (int i = 0; i < 256; i++) begin
      run(1'b1, 1'b0, 32'(i * 4), 4'hF, $urandom, 1'b0, "fill");
    end

    // Full-word write, then read back.
    run(1'b1, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, "wr10");
    run(1'b0, 1'b1, 32'h10, 4'h0, 32'h0, 1'b0, "rd10");
    check_eq("rd10_value", last_rd, 32'hDEADBEEF);

    // Partial byte-lane write.
    run(1'b1, 1'b0, 32'h20, 4'hF, 32'h11223344, 1'b0, "wr20");
    run(1'b1, 1'b0, 32'h20, 4'b0101, 32'hAABBCCDD, 1'b0, "wr20_be");
    run(1'b0, 1'b1, 32'h20, 4'h0, 32'h0, 1'b0, "rd20");
    check_eq("rd20_value", last_rd, 32'h11BB33DD);

    // Address aliasing modulo 1 KiB; low address bits ignored.
    run(1'b1, 1'b0, 32'h400, 4'hF, 32'h5, 1'b0, "wr400");
    run(1'b0, 1'b1, 32'h000, 4'h0, 32'h0, 1'b0, "rd000");
    check_eq("alias_value", last_rd, 32'h5);
    run(1'b0, 1'b1, 32'h403, 4'h0, 32'h0, 1'b0, "rd403");
    check_eq("alias403_value", last_rd, 32'h5);

    // Reset in the second WAIT cycle aborts the write.
    run(1'b1, 1'b0, 32'h8, 4'hF, 32'h0, 1'b0, "wr8");
    mem_write       = 1'b1;
    mem_address     = 32'h8;
    mem_byte_enable = 4'hF;
    mem_wdata       = 32'h1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst       = 1'b1;
    mem_write = 1'b0;
    @(posedge clk); #1;
    rst      = 1'b0;
    last_rd  = 32'd0;
    saw_resp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (mem_resp) saw_resp = 1'b1;
      @(posedge clk); #1;
    end
    check_eq("abort_no_resp", 32'(saw_resp), 32'd0);
    check_eq("abort_rdata_cleared", mem_rdata, 32'd0);
    run(1'b0, 1'b1, 32'h8, 4'h0, 32'h0, 1'b0, "rd8_after_abort");
    check_eq("abort_mem_value", last_rd, 32'h0);

    // Random traffic. Without the checker, inputs may also wander during WAIT.
    for (int n = 0; n < 200; n++) begin
      a  = $urandom;
      d  = $urandom;
      be = 4'($urandom);
      wr = 1'($urandom);
      rd = 1'($urandom);
      if (!wr && !rd) rd = 1'b1;
      if (PROTO_EN) begin
        if (wr && rd) wr = 1'b0;
        if (be == 4'd0) be = 4'hF;
      end
      run(wr, rd, a, be, d, !PROTO_EN, "rand");
    end
    check_eq("rand_proto_err", 32'(proto_err), 32'd0);

    // Read and write both high: the request acts as a read.
    a = 32'h30;
    run(1'b1, 1'b0, a, 4'hF, 32'hCAFEF00D, 1'b0, "wr30");
    run(1'b1, 1'b1, a, 4'hF, 32'h12345678, 1'b0, "both30");
    check_eq("both30_value", last_rd, 32'hCAFEF00D);
    check_eq("both_proto_err", 32'(proto_err), 32'(PROTO_EN));
    run(1'b0, 1'b1, a, 4'h0, 32'h0, 1'b0, "rd30");
    check_eq("both_no_write", last_rd, 32'hCAFEF00D);
    check_eq("proto_err_sticky", 32'(proto_err), 32'(PROTO_EN));
    pulse_reset();
    check_eq("proto_err_reset", 32'(proto_err), 32'd0);

    // A write with no lanes enabled still responds and leaves the word alone.
    run(1'b1, 1'b0, a, 4'h0, 32'hFFFFFFFF, 1'b0, "wr_be0");
    run(1'b0, 1'b1, a, 4'h0, 32'h0, 1'b0, "rd_be0");
    check_eq("be0_value", last_rd, 32'hCAFEF00D);
    check_eq("be0_proto_err", 32'(proto_err), 32'(PROTO_EN));
    pulse_reset();

    // LATENCY=1, back-to-back: each request is presented during the previous response.
    for (int n = 0; n < 56; n++) begin
      wr = (n < 16) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
      a  = (n < 16) ? 32'(n * 4) : $urandom;
      if (n == 0) begin
        l1_write       = wr;
        l1_read        = !wr;
        l1_address     = a;
        l1_byte_enable = 4'hF;
        l1_wdata       = $urandom;
      end
      // Acceptance edge; the response is due in the very next cycle.
      @(posedge clk); #1;
      check_eq("l1_resp_high", 32'(l1_resp), 32'd1);
      if (l1_write) begin
        ref_mem1[int'(l1_address[5:2])] = l1_wdata;
      end else begin
        check_eq("l1_rdata", l1_rdata, ref_mem1[int'(l1_address[5:2])]);
      end
      if (n < 55) begin
        wr             = (n + 1 < 16) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
        l1_write       = wr;
        l1_read        = !wr;
        l1_address     = (n + 1 < 16) ? 32'((n + 1) * 4) : $urandom;
        l1_byte_enable = 4'hF;
        l1_wdata       = $urandom;
      end else begin
        l1_write = 1'b0;
        l1_read  = 1'b0;
      end
      @(posedge clk); #1;
      check_eq("l1_resp_gap", 32'(l1_resp), 32'd0);
    end
    check_eq("l1_proto_err", 32'(l1_proto_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
